// File: rtl/sad_fsbm_top.sv
// sad_fsbm_top: full-search block-matching SAD engine for one 16x16 block pair.
//
// Thirty-two byte-wide FIFOs, each 16 deep, are filled in parallel. Each FIFO
// holds one image row:
//   - even FIFO 2k holds row k of reference block A;
//   - odd FIFO 2k+1 holds row k of candidate block B.
// When every FIFO is full, the controller pops all FIFOs together, one column
// per cycle, for 16 cycles. The sum of |A-B| over each column is added into
// sad_reg. The final SAD is valid 17 cycles after the IDLE->READ edge.
//
// Ports
//   clk                        in   1   clock, rising edge
//   rst                        in   1   asynchronous reset, active low
//   wr                         in   1   write strobe shared by all FIFOs
//   data_in0..31               in   8   pixel into FIFO n
//   empty0..31 / full0..31     out  1   FIFO n occupancy flags
//   FIFO_count0..31            out  5   FIFO n occupancy, 0..16
//   data_out0..31              out  8   registered read data of FIFO n
//   sad_reg                    out  32  SAD accumulator / final result
//   i                          out  5   column index of the current read
module sad_fsbm_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [7:0]  data_in0,  data_in1,  data_in2,  data_in3,  data_in4,  data_in5,  data_in6,  data_in7,
  input  logic [7:0]  data_in8,  data_in9,  data_in10, data_in11, data_in12, data_in13, data_in14, data_in15,
  input  logic [7:0]  data_in16, data_in17, data_in18, data_in19, data_in20, data_in21, data_in22, data_in23,
  input  logic [7:0]  data_in24, data_in25, data_in26, data_in27, data_in28, data_in29, data_in30, data_in31,
  output logic        empty0,  empty1,  empty2,  empty3,  empty4,  empty5,  empty6,  empty7,
  output logic        empty8,  empty9,  empty10, empty11, empty12, empty13, empty14, empty15,
  output logic        empty16, empty17, empty18, empty19, empty20, empty21, empty22, empty23,
  output logic        empty24, empty25, empty26, empty27, empty28, empty29, empty30, empty31,
  output logic        full0,  full1,  full2,  full3,  full4,  full5,  full6,  full7,
  output logic        full8,  full9,  full10, full11, full12, full13, full14, full15,
  output logic        full16, full17, full18, full19, full20, full21, full22, full23,
  output logic        full24, full25, full26, full27, full28, full29, full30, full31,
  output logic [4:0]  FIFO_count0,  FIFO_count1,  FIFO_count2,  FIFO_count3,
  output logic [4:0]  FIFO_count4,  FIFO_count5,  FIFO_count6,  FIFO_count7,
  output logic [4:0]  FIFO_count8,  FIFO_count9,  FIFO_count10, FIFO_count11,
  output logic [4:0]  FIFO_count12, FIFO_count13, FIFO_count14, FIFO_count15,
  output logic [4:0]  FIFO_count16, FIFO_count17, FIFO_count18, FIFO_count19,
  output logic [4:0]  FIFO_count20, FIFO_count21, FIFO_count22, FIFO_count23,
  output logic [4:0]  FIFO_count24, FIFO_count25, FIFO_count26, FIFO_count27,
  output logic [4:0]  FIFO_count28, FIFO_count29, FIFO_count30, FIFO_count31,
  output logic [7:0]  data_out0,  data_out1,  data_out2,  data_out3,  data_out4,  data_out5,  data_out6,  data_out7,
  output logic [7:0]  data_out8,  data_out9,  data_out10, data_out11, data_out12, data_out13, data_out14, data_out15,
  output logic [7:0]  data_out16, data_out17, data_out18, data_out19, data_out20, data_out21, data_out22, data_out23,
  output logic [7:0]  data_out24, data_out25, data_out26, data_out27, data_out28, data_out29, data_out30, data_out31,
  output logic [31:0] sad_reg,
  output logic [4:0]  i
);

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NF    = 32;
  localparam int NR    = NF / 2;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_ACC, ST_DONE} state_e;

  logic [NF*DW-1:0] din_flat_s;
  logic [NF*DW-1:0] dout_flat_s;
  logic [NF*5-1:0]  cnt_flat_s;
  logic [DW-1:0]    din_s  [NF];
  logic [DW-1:0]    dout_q [NF];
  logic [DW-1:0]    mem_q  [NF][DEPTH];
  logic [3:0]       wptr_q [NF];
  logic [3:0]       rptr_q [NF];
  logic [4:0]       cnt_q  [NF];
  logic [NF-1:0]    empty_s, full_s, wr_en_s, rd_en_s;
  logic [DW-1:0]    diff_s [NR];
  logic [11:0]      sum_s;
  state_e           state_q, state_d;
  logic             rd_s, start_s, acc_v_q;
  logic [31:0]      sad_q;
  logic [4:0]       i_q;

  assign din_flat_s = {data_in31, data_in30, data_in29, data_in28, data_in27, data_in26, data_in25, data_in24,
                       data_in23, data_in22, data_in21, data_in20, data_in19, data_in18, data_in17, data_in16,
                       data_in15, data_in14, data_in13, data_in12, data_in11, data_in10, data_in9,  data_in8,
                       data_in7,  data_in6,  data_in5,  data_in4,  data_in3,  data_in2,  data_in1,  data_in0};
  assign {empty31, empty30, empty29, empty28, empty27, empty26, empty25, empty24,
          empty23, empty22, empty21, empty20, empty19, empty18, empty17, empty16,
          empty15, empty14, empty13, empty12, empty11, empty10, empty9,  empty8,
          empty7,  empty6,  empty5,  empty4,  empty3,  empty2,  empty1,  empty0} = empty_s;
  assign {full31, full30, full29, full28, full27, full26, full25, full24,
          full23, full22, full21, full20, full19, full18, full17, full16,
          full15, full14, full13, full12, full11, full10, full9,  full8,
          full7,  full6,  full5,  full4,  full3,  full2,  full1,  full0} = full_s;
  assign {FIFO_count31, FIFO_count30, FIFO_count29, FIFO_count28, FIFO_count27, FIFO_count26, FIFO_count25, FIFO_count24,
          FIFO_count23, FIFO_count22, FIFO_count21, FIFO_count20, FIFO_count19, FIFO_count18, FIFO_count17, FIFO_count16,
          FIFO_count15, FIFO_count14, FIFO_count13, FIFO_count12, FIFO_count11, FIFO_count10, FIFO_count9,  FIFO_count8,
          FIFO_count7,  FIFO_count6,  FIFO_count5,  FIFO_count4,  FIFO_count3,  FIFO_count2,  FIFO_count1,  FIFO_count0} = cnt_flat_s;
  assign {data_out31, data_out30, data_out29, data_out28, data_out27, data_out26, data_out25, data_out24,
          data_out23, data_out22, data_out21, data_out20, data_out19, data_out18, data_out17, data_out16,
          data_out15, data_out14, data_out13, data_out12, data_out11, data_out10, data_out9,  data_out8,
          data_out7,  data_out6,  data_out5,  data_out4,  data_out3,  data_out2,  data_out1,  data_out0} = dout_flat_s;
  assign sad_reg = sad_q;
  assign i       = i_q;

  for (genvar g = 0; g < NF; g++) begin : g_fifo_io
    assign din_s[g]                 = din_flat_s[g*DW +: DW];
    assign dout_flat_s[g*DW +: DW]  = dout_q[g];
    assign cnt_flat_s[g*5 +: 5]     = cnt_q[g];
    assign empty_s[g]               = (cnt_q[g] == 5'd0);
    assign full_s[g]                = (cnt_q[g] == 5'd16);
    assign wr_en_s[g]               = wr && !full_s[g];
    assign rd_en_s[g]               = rd_s && !empty_s[g];
  end

  // FIFO storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NF; k++) begin
      if (wr_en_s[k]) begin
        mem_q[k][wptr_q[k]] <= din_s[k];
      end
    end
  end

  // FIFO pointers, occupancy and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NF; k++) begin
        wptr_q[k] <= 4'd0;
        rptr_q[k] <= 4'd0;
        cnt_q[k]  <= 5'd0;
        dout_q[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NF; k++) begin
        if (wr_en_s[k]) begin
          wptr_q[k] <= wptr_q[k] + 4'd1;
        end
        if (rd_en_s[k]) begin
          rptr_q[k] <= rptr_q[k] + 4'd1;
          dout_q[k] <= mem_q[k][rptr_q[k]];
        end
        case ({wr_en_s[k], rd_en_s[k]})
          2'b10:   cnt_q[k] <= cnt_q[k] + 5'd1;
          2'b01:   cnt_q[k] <= cnt_q[k] - 5'd1;
          default: cnt_q[k] <= cnt_q[k];
        endcase
      end
    end
  end

  // Controller next state; READ lasts while i walks 0..15.
  always_comb begin
    state_d = state_q;
    rd_s    = 1'b0;
    start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (&full_s) begin
          state_d = ST_READ;
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_s = 1'b1;
        if (i_q == 5'd15) begin
          state_d = ST_ACC;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_ACC:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-row absolute differences on the column just popped, then summed.
  for (genvar g = 0; g < NR; g++) begin : g_absdiff
    assign diff_s[g] = (dout_q[2*g] >= dout_q[2*g+1]) ? (dout_q[2*g] - dout_q[2*g+1])
                                                      : (dout_q[2*g+1] - dout_q[2*g]);
  end

  // Column sum of the 16 row differences (max 4080 fits 12 bits).
  always_comb begin
    sum_s = 12'd0;
    for (int k = 0; k < NR; k++) begin
      sum_s = sum_s + {4'd0, diff_s[k]};
    end
  end

  // Controller state, column index and accumulator; acc_v trails rd by one
  // cycle so it lines up with the registered FIFO read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_v_q <= 1'b0;
      sad_q   <= 32'd0;
      i_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_v_q <= rd_s;
      if (start_s) begin
        sad_q <= 32'd0;
        i_q   <= 5'd0;
      end else begin
        if (acc_v_q) begin
          sad_q <= sad_q + {20'd0, sum_s};
        end
        if (rd_s && (i_q != 5'd15)) begin
          i_q <= i_q + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_fsbm_top.sv
module tb_sad_fsbm_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr  = 1'b0;
  logic [7:0]  din  [32];
  logic        emp  [32];
  logic        ful  [32];
  logic [4:0]  cnt  [32];
  logic [7:0]  dout [32];
  logic [31:0] sad;
  logic [4:0]  idx;

  logic [7:0]  blk_a [16][16];
  logic [7:0]  blk_b [16][16];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  sad_fsbm_top dut (
    .clk(clk), .rst(rst), .wr(wr),
    .data_in0(din[0]),   .data_in1(din[1]),   .data_in2(din[2]),   .data_in3(din[3]),
    .data_in4(din[4]),   .data_in5(din[5]),   .data_in6(din[6]),   .data_in7(din[7]),
    .data_in8(din[8]),   .data_in9(din[9]),   .data_in10(din[10]), .data_in11(din[11]),
    .data_in12(din[12]), .data_in13(din[13]), .data_in14(din[14]), .data_in15(din[15]),
    .data_in16(din[16]), .data_in17(din[17]), .data_in18(din[18]), .data_in19(din[19]),
    .data_in20(din[20]), .data_in21(din[21]), .data_in22(din[22]), .data_in23(din[23]),
    .data_in24(din[24]), .data_in25(din[25]), .data_in26(din[26]), .data_in27(din[27]),
    .data_in28(din[28]), .data_in29(din[29]), .data_in30(din[30]), .data_in31(din[31]),
    .empty0(emp[0]),   .empty1(emp[1]),   .empty2(emp[2]),   .empty3(emp[3]),
    .empty4(emp[4]),   .empty5(emp[5]),   .empty6(emp[6]),   .empty7(emp[7]),
    .empty8(emp[8]),   .empty9(emp[9]),   .empty10(emp[10]), .empty11(emp[11]),
    .empty12(emp[12]), .empty13(emp[13]), .empty14(emp[14]), .empty15(emp[15]),
    .empty16(emp[16]), .empty17(emp[17]), .empty18(emp[18]), .empty19(emp[19]),
    .empty20(emp[20]), .empty21(emp[21]), .empty22(emp[22]), .empty23(emp[23]),
    .empty24(emp[24]), .empty25(emp[25]), .empty26(emp[26]), .empty27(emp[27]),
    .empty28(emp[28]), .empty29(emp[29]), .empty30(emp[30]), .empty31(emp[31]),
    .full0(ful[0]),   .full1(ful[1]),   .full2(ful[2]),   .full3(ful[3]),
    .full4(ful[4]),   .full5(ful[5]),   .full6(ful[6]),   .full7(ful[7]),
    .full8(ful[8]),   .full9(ful[9]),   .full10(ful[10]), .full11(ful[11]),
    .full12(ful[12]), .full13(ful[13]), .full14(ful[14]), .full15(ful[15]),
    .full16(ful[16]), .full17(ful[17]), .full18(ful[18]), .full19(ful[19]),
    .full20(ful[20]), .full21(ful[21]), .full22(ful[22]), .full23(ful[23]),
    .full24(ful[24]), .full25(ful[25]), .full26(ful[26]), .full27(ful[27]),
    .full28(ful[28]), .full29(ful[29]), .full30(ful[30]), .full31(ful[31]),
    .FIFO_count0(cnt[0]),   .FIFO_count1(cnt[1]),   .FIFO_count2(cnt[2]),   .FIFO_count3(cnt[3]),
    .FIFO_count4(cnt[4]),   .FIFO_count5(cnt[5]),   .FIFO_count6(cnt[6]),   .FIFO_count7(cnt[7]),
    .FIFO_count8(cnt[8]),   .FIFO_count9(cnt[9]),   .FIFO_count10(cnt[10]), .FIFO_count11(cnt[11]),
    .FIFO_count12(cnt[12]), .FIFO_count13(cnt[13]), .FIFO_count14(cnt[14]), .FIFO_count15(cnt[15]),
    .FIFO_count16(cnt[16]), .FIFO_count17(cnt[17]), .FIFO_count18(cnt[18]), .FIFO_count19(cnt[19]),
    .FIFO_count20(cnt[20]), .FIFO_count21(cnt[21]), .FIFO_count22(cnt[22]), .FIFO_count23(cnt[23]),
    .FIFO_count24(cnt[24]), .FIFO_count25(cnt[25]), .FIFO_count26(cnt[26]), .FIFO_count27(cnt[27]),
    .FIFO_count28(cnt[28]), .FIFO_count29(cnt[29]), .FIFO_count30(cnt[30]), .FIFO_count31(cnt[31]),
    .data_out0(dout[0]),   .data_out1(dout[1]),   .data_out2(dout[2]),   .data_out3(dout[3]),
    .data_out4(dout[4]),   .data_out5(dout[5]),   .data_out6(dout[6]),   .data_out7(dout[7]),
    .data_out8(dout[8]),   .data_out9(dout[9]),   .data_out10(dout[10]), .data_out11(dout[11]),
    .data_out12(dout[12]), .data_out13(dout[13]), .data_out14(dout[14]), .data_out15(dout[15]),
    .data_out16(dout[16]), .data_out17(dout[17]), .data_out18(dout[18]), .data_out19(dout[19]),
    .data_out20(dout[20]), .data_out21(dout[21]), .data_out22(dout[22]), .data_out23(dout[23]),
    .data_out24(dout[24]), .data_out25(dout[25]), .data_out26(dout[26]), .data_out27(dout[27]),
    .data_out28(dout[28]), .data_out29(dout[29]), .data_out30(dout[30]), .data_out31(dout[31]),
    .sad_reg(sad), .i(idx)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference SAD: sum over all pixels of the unsigned absolute difference.
  function automatic logic [31:0] model_sad();
    int total = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        total += (blk_a[r][c] > blk_b[r][c]) ? int'(blk_a[r][c]) - int'(blk_b[r][c])
                                             : int'(blk_b[r][c]) - int'(blk_a[r][c]);
    return 32'(total);
  endfunction

  function automatic logic [31:0] count_total();
    int t = 0;
    for (int k = 0; k < 32; k++) t += int'(cnt[k]);
    return 32'(t);
  endfunction

  function automatic logic [31:0] full_vec();
    logic [31:0] v = 32'd0;
    for (int k = 0; k < 32; k++) v[k] = ful[k];
    return v;
  endfunction

  function automatic logic [31:0] empty_vec();
    logic [31:0] v = 32'd0;
    for (int k = 0; k < 32; k++) v[k] = emp[k];
    return v;
  endfunction

  // Write columns first..last of the current block, one column per cycle.
  task automatic write_cols(input int first, input int last);
    for (int c = first; c <= last; c++) begin
      for (int r = 0; r < 16; r++) begin
        din[2*r]   = blk_a[r][c];
        din[2*r+1] = blk_b[r][c];
      end
      wr = 1'b1;
      @(posedge clk); #1;
    end
    wr = 1'b0;
  endtask

  // Load a full block, wait the fixed latency and compare with the model.
  task automatic run_block(input string tag);
    logic [31:0] exp;
    exp = model_sad();
    write_cols(0, 15);
    repeat (18) @(posedge clk);
    #1;
    check_value({tag, "_sad"}, sad, exp);
    check_value({tag, "_i"}, {27'd0, idx}, 32'd15);
    check_value({tag, "_cnt"}, count_total(), 32'd0);
  endtask

  initial begin
    logic [31:0] exp;
    for (int k = 0; k < 32; k++) din[k] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_sad", sad, 32'd0);
    check_value("rst_i", {27'd0, idx}, 32'd0);
    check_value("rst_cnt", count_total(), 32'd0);
    check_value("rst_empty", empty_vec(), 32'hFFFF_FFFF);
    check_value("rst_full", full_vec(), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Partial fill, then the 16th write starts the drain.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        blk_a[r][c] = 8'($urandom_range(0, 255));
        blk_b[r][c] = 8'($urandom_range(0, 255));
      end
    exp = model_sad();
    write_cols(0, 14);
    repeat (3) @(posedge clk);
    #1;
    check_value("part_cnt", count_total(), 32'd480);
    check_value("part_full", full_vec(), 32'd0);
    check_value("part_sad", sad, 32'd0);
    write_cols(15, 15);
    check_value("part_full16", full_vec(), 32'hFFFF_FFFF);
    repeat (18) @(posedge clk);
    #1;
    check_value("part_sad_final", sad, exp);
    check_value("part_empty", empty_vec(), 32'hFFFF_FFFF);

    // Identical random blocks.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        blk_a[r][c] = 8'($urandom_range(0, 255));
        blk_b[r][c] = blk_a[r][c];
      end
    run_block("ident");
    check_value("ident_zero", sad, 32'd0);

    // Extreme: A all 0xFF, B all 0x00.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        blk_a[r][c] = 8'hFF;
        blk_b[r][c] = 8'h00;
      end
    run_block("extreme");
    check_value("extreme_const", sad, 32'd65280);

    // Ramp, B one above A (8-bit wrap at the last pixel is part of the model).
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        blk_a[r][c] = 8'(16*r + c);
        blk_b[r][c] = 8'(16*r + c + 1);
      end
    run_block("ramp_up");

    // Ramp, B one below A, shifted so every A pixel is at least 1.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        blk_a[r][c] = 8'((16*r + c) % 255 + 1);
        blk_b[r][c] = 8'((16*r + c) % 255);
      end
    run_block("ramp_dn");
    check_value("ramp_dn_const", sad, 32'd256);

    // Overflow: one extra write while full must be dropped.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        blk_a[r][c] = 8'($urandom_range(0, 255));
        blk_b[r][c] = 8'($urandom_range(0, 255));
      end
    exp = model_sad();
    write_cols(0, 15);
    for (int k = 0; k < 32; k++) din[k] = 8'($urandom_range(0, 255));
    wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    check_value("ovf_cnt", count_total(), 32'd512);
    repeat (17) @(posedge clk);
    #1;
    check_value("ovf_sad", sad, exp);
    check_value("ovf_cnt_end", count_total(), 32'd0);

    // Reset in the middle of a drain.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        blk_a[r][c] = 8'hF0;
        blk_b[r][c] = 8'h0F;
      end
    write_cols(0, 15);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_value("mid_rst_cnt", count_total(), 32'd0);
    check_value("mid_rst_sad", sad, 32'd0);
    check_value("mid_rst_i", {27'd0, idx}, 32'd0);
    check_value("mid_rst_empty", empty_vec(), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // A few random blocks after the abort.
    for (int n = 0; n < 4; n++) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          blk_a[r][c] = 8'($urandom_range(0, 255));
          blk_b[r][c] = 8'($urandom_range(0, 255));
        end
      run_block($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
